// File: rtl/uio_bus_arbiter.sv
// Round-robin arbiter sharing the 8-bit uio pad bus among NUM_REQ requesters,
// with turnaround cycles on direction changes and a per-grant beat cap.
module uio_bus_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int BURST_MAX   = 4,
  parameter int TURN_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   dir,
  input  logic [8*NUM_REQ-1:0] wdata,
  output logic [NUM_REQ-1:0]   grant,
  output logic [7:0]           rdata,
  output logic                 rvalid,
  input  logic [7:0]           uio_in,
  output logic [7:0]           uio_out,
  output logic [7:0]           uio_oe,
  output logic                 busy
);

  localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, TURN, XFER} state_t;

  state_t               r_state,    w_state;
  logic                 r_bus_dir,  w_bus_dir;
  logic [3:0]           r_beat_cnt, w_beat_cnt;
  logic [1:0]           r_turn_cnt, w_turn_cnt;
  logic [LW-1:0]        r_last,     w_last;
  logic [LW-1:0]        r_win,      w_win;
  logic                 r_wdir,     w_wdir;
  logic [NUM_REQ-1:0]   r_grant,    w_grant;
  logic [7:0]           r_rdata,    w_rdata;
  logic                 r_rvalid,   w_rvalid;
  logic [7:0]           r_uio_out,  w_uio_out;
  logic [7:0]           r_uio_oe,   w_uio_oe;
  logic                 r_busy;

  logic                 w_found;
  logic [LW-1:0]        w_sel;
  logic [3:0]           w_cnt_inc;
  logic [NUM_REQ-1:0]   w_onehot;

  // Search starts just after the last winner, so the most recent grantee ranks lowest.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      if (!w_found && req[LW'((int'(r_last) + k) % NUM_REQ)]) begin
        w_found = 1'b1;
        w_sel   = LW'((int'(r_last) + k) % NUM_REQ);
      end
    end
  end

  assign w_cnt_inc = r_beat_cnt + 4'd1;
  assign w_onehot  = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_win;

  always_comb begin
    w_state    = r_state;
    w_bus_dir  = r_bus_dir;
    w_beat_cnt = r_beat_cnt;
    w_turn_cnt = r_turn_cnt;
    w_last     = r_last;
    w_win      = r_win;
    w_wdir     = r_wdir;
    w_grant    = r_grant;
    w_rdata    = r_rdata;
    w_rvalid   = 1'b0;
    w_uio_out  = r_uio_out;
    w_uio_oe   = r_uio_oe;
    if (!ena) begin
      w_state    = IDLE;
      w_bus_dir  = 1'b0;
      w_beat_cnt = '0;
      w_turn_cnt = '0;
      w_grant    = '0;
      w_uio_out  = '0;
      w_uio_oe   = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_found) begin
            w_win  = w_sel;
            w_wdir = dir[w_sel];
            if (dir[w_sel] == r_bus_dir) begin
              w_state = XFER;
              w_grant = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_sel;
            end else begin
              w_state    = TURN;
              w_turn_cnt = '0;
              w_uio_oe   = '0;
              w_uio_out  = '0;
            end
          end
        end
        TURN: begin
          if (r_turn_cnt == 2'(TURN_CYCLES - 1)) begin
            w_state   = XFER;
            w_bus_dir = r_wdir;
            w_grant   = w_onehot;
            w_uio_oe  = r_wdir ? 8'hFF : 8'h00;
          end else begin
            w_turn_cnt = r_turn_cnt + 2'd1;
          end
        end
        XFER: begin
          if (req[r_win]) begin
            w_beat_cnt = w_cnt_inc;
            if (r_wdir) begin
              w_uio_out = wdata[{r_win, 3'b000} +: 8];
            end else begin
              w_rdata  = uio_in;
              w_rvalid = 1'b1;
            end
          end
          if (!req[r_win] || (w_cnt_inc == 4'(BURST_MAX))) begin
            w_state    = IDLE;
            w_grant    = '0;
            w_last     = r_win;
            w_beat_cnt = '0;
          end
        end
        default: w_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_bus_dir  <= 1'b0;
      r_beat_cnt <= '0;
      r_turn_cnt <= '0;
      r_last     <= LW'(NUM_REQ - 1);
      r_win      <= '0;
      r_wdir     <= 1'b0;
      r_grant    <= '0;
      r_rdata    <= '0;
      r_rvalid   <= 1'b0;
      r_uio_out  <= '0;
      r_uio_oe   <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_bus_dir  <= w_bus_dir;
      r_beat_cnt <= w_beat_cnt;
      r_turn_cnt <= w_turn_cnt;
      r_last     <= w_last;
      r_win      <= w_win;
      r_wdir     <= w_wdir;
      r_grant    <= w_grant;
      r_rdata    <= w_rdata;
      r_rvalid   <= w_rvalid;
      r_uio_out  <= w_uio_out;
      r_uio_oe   <= w_uio_oe;
      r_busy     <= (w_state != IDLE);
    end
  end

  assign grant   = r_grant;
  assign rdata   = r_rdata;
  assign rvalid  = r_rvalid;
  assign uio_out = r_uio_out;
  assign uio_oe  = r_uio_oe;
  assign busy    = r_busy;

endmodule

// File: doc/uio_bus_arbiter.md
Name: uio_bus_arbiter

Overview:
- Round-robin arbiter that shares the 8-bit bidirectional uio pad bus (uio_in/uio_out/uio_oe) among NUM_REQ internal requesters inside the user project.
- Each requester asks for a read or write burst. The arbiter grants one requester at a time.
- It inserts turnaround cycles, with the pads released, on every bus-direction change.
- It caps each grant at BURST_MAX beats and gates all activity with ena.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- BURST_MAX, 4, maximum beats per grant (1..15).
- TURN_CYCLES, 1, cycles with uio_oe=0 on each direction change (1..3).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  design enable; 0 aborts and releases the bus
- req  in  NUM_REQ  per-requester request, level
- dir  in  NUM_REQ  per-requester direction: 1=write to pads, 0=read from pads
- wdata  in  8*NUM_REQ  write data; requester i uses bits [8i+7:8i]
- grant  out  NUM_REQ  one-hot grant, registered
- rdata  out  8  captured pad data, registered
- rvalid  out  1  one-cycle pulse, rdata valid
- uio_in  in  8  pad input path
- uio_out  out  8  pad output path, registered
- uio_oe  out  8  pad output enable: 8'hFF or 8'h00 only, registered
- busy  out  1  high in TURN or XFER

Behaviour:
- Reset (async, rst_n=0), all outputs 0:
  - grant=0, rdata=0, rvalid=0, uio_out=0, uio_oe=0, busy=0.
  - state=IDLE, bus_dir=read, beat_cnt=0, last=NUM_REQ-1, so requester 0 has top priority.
- States: IDLE, TURN, XFER.
- IDLE:
  - If ena=1 and req!=0, select the winner w as the first set req bit searching last+1, last+2, ... modulo NUM_REQ.
  - Latch w and dir[w]. dir[w] is ignored for the rest of the grant.
  - If dir[w]==bus_dir, go to XFER: grant[w]=1 from the next cycle.
  - Otherwise go to TURN: uio_oe=0 and uio_out=0 from the next cycle.
- TURN:
  - Hold for exactly TURN_CYCLES cycles.
  - Then set bus_dir=dir[w] and go to XFER. grant[w] rises at the same edge.
  - For a write, uio_oe=8'hFF from that same edge.
- XFER, beat definition: a beat is any cycle with grant[w]=1 and req[w]=1.
  - Write beat: uio_out <= wdata[w] at the next edge (one-cycle latency to the pads).
  - Read beat: rdata <= uio_in and rvalid=1 for the following cycle.
  - Each beat increments beat_cnt.
- XFER exit:
  - Exit if req[w]=0 in a granted cycle (no beat in that cycle), or on the beat that makes beat_cnt==BURST_MAX.
  - On exit, at the next edge: grant=0, last=w, beat_cnt=0, go to IDLE.
  - This leaves a minimum of one dead cycle between grants.
- Bus parking between grants:
  - After a write grant, uio_oe stays 8'hFF and uio_out holds its last value until a read is granted (via TURN) or ena drops.
  - After a read grant, uio_oe stays 0.
- Back-to-back: a same-direction winner gets no TURN. The latency from the IDLE decision to grant is 1 cycle.
- Simultaneous requests: resolved only by the round-robin pointer. Requests raised during a grant wait until IDLE.
- ena=0 in any state, at the next edge:
  - grant=0, uio_oe=0, uio_out=0, bus_dir=read, state=IDLE, beat_cnt=0.
  - A pending rvalid is cleared.
  - last is preserved.
- rst_n asserted mid-burst: all state clears immediately (async). No partial beat is reported.
- busy = (state!=IDLE), registered.

Test Plan:
- Reset then idle: rst_n=0→1, ena=1, req=0 → all outputs 0 for 10 cycles; uio_oe=8'h00.
- Single write: req[0]=1, dir[0]=1, wdata0 = 8'hA5, 8'h5A, 8'h3C over 3 beats, then req[0]=0.
  - Bus starts in read, so TURN of 1 cycle first.
  - grant[0] rises 2 cycles after req; uio_oe=8'hFF with the grant.
  - uio_out shows A5, 5A, 3C each one cycle after its beat.
  - grant drops 1 cycle after req falls; uio_oe stays 8'hFF.
- Round-robin contention: req=4'b1111, all reads, BURST_MAX=4, req held.
  - Grants go 0,1,2,3,0 in order.
  - Each grant lasts 4 cycles with 1 dead cycle between grants.
  - No TURN cycles occur.
- Turnaround: requester 1 writes 2 beats, then requester 2 reads with uio_in=8'hC3.
  - TURN_CYCLES=1 cycle with uio_oe=0 before grant[2].
  - rdata=8'hC3 with an rvalid pulse one cycle after each read beat.
- Burst cap: requester 3 holds req for 10 cycles, BURST_MAX=4, no other requests.
  - grant[3] lasts 4 cycles, drops for 1 dead cycle, then is re-granted.
- Abort: ena=0 during the 2nd beat of a write burst.
  - Next cycle: grant=0, uio_oe=0, uio_out=0, busy=0.
  - With ena=1 again, a read request is granted with no TURN (bus_dir=read).
